// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter with clear, clamped load, wrap/saturate
// modes, combinational terminal count and a registered one-cycle wrap pulse.
module param_updown_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 2**WIDTH,
   parameter bit SATURATE = 1'b0
) (
   input  logic             CLK,
   input  logic             ResetN,
   input  logic             Clr,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   input  logic             En,
   input  logic             DNUP,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             Wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic             at_max;
   logic             at_zero;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;

   assign at_max  = (Q == MAX_VAL);
   assign at_zero = (Q == '0);
   assign TC      = En & (DNUP ? at_zero : at_max);

   always_comb begin
      q_nxt    = Q;
      wrap_nxt = 1'b0;
      if (Clr) begin
         q_nxt = '0;
      end else if (Load) begin
         // Out-of-range load values clamp so Q never leaves 0..MODULUS-1
         q_nxt = (D > MAX_VAL) ? MAX_VAL : D;
      end else if (En) begin
         if (!DNUP) begin
            if (!at_max) begin
               q_nxt = Q + ONE;
            end else if (!SATURATE) begin
               q_nxt    = '0;
               wrap_nxt = 1'b1;
            end
         end else begin
            if (!at_zero) begin
               q_nxt = Q - ONE;
            end else if (!SATURATE) begin
               q_nxt    = MAX_VAL;
               wrap_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         Q    <= '0;
         Wrap <= 1'b0;
      end else begin
         Q    <= q_nxt;
         Wrap <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed-vector bench for param_updown_counter: decade, saturating, modulo-8
// reset and two-stage cascade instances checked through an expectation queue.
module tb_param_updown_counter;

   typedef struct {
      int    id;
      int    q;
      logic  tc;
      logic  wrap;
      string name;
   } exp_t;

   logic       clk;
   logic       rst [4];
   logic       clr [4];
   logic       ld  [4];
   logic [3:0] dd  [4];
   logic       en  [4];
   logic       dnup[4];
   logic [3:0] q   [4];
   logic       tc  [4];
   logic       wr  [4];
   logic [2:0] q8;
   logic [3:0] qb;
   logic       tcb;
   logic       wrb;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   event chk_ev;

   // Decade counter
   param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_dec (
      .CLK(clk), .ResetN(rst[0]), .Clr(clr[0]), .Load(ld[0]), .D(dd[0]),
      .En(en[0]), .DNUP(dnup[0]), .Q(q[0]), .TC(tc[0]), .Wrap(wr[0]));

   // Saturating full-range counter
   param_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b1)) u_sat (
      .CLK(clk), .ResetN(rst[1]), .Clr(clr[1]), .Load(ld[1]), .D(dd[1]),
      .En(en[1]), .DNUP(dnup[1]), .Q(q[1]), .TC(tc[1]), .Wrap(wr[1]));

   // Modulo-8 counter for the asynchronous reset case
   param_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_m8 (
      .CLK(clk), .ResetN(rst[2]), .Clr(clr[2]), .Load(ld[2]), .D(3'd0),
      .En(en[2]), .DNUP(dnup[2]), .Q(q8), .TC(tc[2]), .Wrap(wr[2]));

   // Two-stage decade cascade: units then tens
   param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_cas0 (
      .CLK(clk), .ResetN(rst[3]), .Clr(clr[3]), .Load(ld[3]), .D(dd[3]),
      .En(en[3]), .DNUP(dnup[3]), .Q(q[3]), .TC(tc[3]), .Wrap(wr[3]));

   param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_cas1 (
      .CLK(clk), .ResetN(rst[3]), .Clr(1'b0), .Load(1'b0), .D(4'd0),
      .En(tc[3]), .DNUP(dnup[3]), .Q(qb), .TC(tcb), .Wrap(wrb));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string nm, input string fld, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s %s: got %0d, expected %0d", nm, fld, act, expv);
      end
   endtask

   // Monitor: compares every queued expectation against the DUT outputs
   initial begin
      exp_t e;
      int   aq;
      logic atc, awr;
      forever begin
         @(negedge clk or chk_ev);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.id)
               0:       begin aq = int'(q[0]); atc = tc[0]; awr = wr[0]; end
               1:       begin aq = int'(q[1]); atc = tc[1]; awr = wr[1]; end
               2:       begin aq = int'(q8);   atc = tc[2]; awr = wr[2]; end
               default: begin aq = int'(qb) * 10 + int'(q[3]); atc = tcb; awr = wrb; end
            endcase
            cmp(e.name, "Q",    aq,       e.q);
            cmp(e.name, "TC",   int'(atc), int'(e.tc));
            cmp(e.name, "Wrap", int'(awr), int'(e.wrap));
         end
      end
   end

   // Apply inputs, queue the outputs expected before the coming edge, then clock.
   task automatic step(input int id, input logic c, input logic l, input logic [3:0] dv,
                       input logic e, input logic dn, input int eq, input logic etc,
                       input logic ew, input string nm);
      clr[id] = c; ld[id] = l; dd[id] = dv; en[id] = e; dnup[id] = dn;
      sb.push_back('{id, eq, etc, ew, nm});
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         rst[i] = 1'b0; clr[i] = 1'b0; ld[i] = 1'b0; dd[i] = 4'd0;
         en[i] = 1'b0; dnup[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) sb.push_back('{i, 0, 1'b0, 1'b0, "reset"});

      // Decade up count: 12 edges, wrap after 9->0
      rst[0] = 1'b1;
      for (int i = 0; i < 12; i++)
         step(0, 0, 0, 4'd0, 1, 0, i % 10, (i % 10) == 9, i == 10, "dec_up");
      step(0, 1, 0, 4'd0, 0, 0, 2, 0, 0, "dec_clr");
      // Decade down count from 0: 9, 8, 7
      step(0, 0, 0, 4'd0, 1, 1, 0, 1, 0, "dec_dn0");
      step(0, 0, 0, 4'd0, 1, 1, 9, 0, 1, "dec_dn9");
      step(0, 0, 0, 4'd0, 1, 1, 8, 0, 0, "dec_dn8");
      step(0, 0, 0, 4'd0, 0, 0, 7, 0, 0, "dec_dn7");
      // Priority Clr over Load over En, then clamped load of 13
      step(0, 1, 1, 4'd5, 1, 0, 7, 0, 0, "prio_pre");
      step(0, 0, 1, 4'd13, 0, 0, 0, 0, 0, "prio_clr");
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, 4'd0, 0, 0, 9, 0, 0, "clamp_hold");
      step(0, 0, 0, 4'd0, 1, 1, 9, 0, 0, "clamp_dn");
      step(0, 0, 0, 4'd0, 0, 0, 8, 0, 0, "clamp_dn8");

      // Saturate: load 14, count up pinned at 15, then load 1 and count down pinned at 0
      rst[1] = 1'b1;
      step(1, 0, 1, 4'd14, 0, 0, 0, 0, 0, "sat_ld14");
      step(1, 0, 0, 4'd0, 1, 0, 14, 0, 0, "sat_up14");
      for (int i = 0; i < 3; i++)
         step(1, 0, 0, 4'd0, 1, 0, 15, 1, 0, "sat_up15");
      step(1, 0, 1, 4'd1, 0, 0, 15, 0, 0, "sat_ld1");
      step(1, 0, 0, 4'd0, 1, 1, 1, 0, 0, "sat_dn1");
      step(1, 0, 0, 4'd0, 1, 1, 0, 1, 0, "sat_dn0a");
      step(1, 0, 0, 4'd0, 1, 1, 0, 1, 0, "sat_dn0b");
      step(1, 0, 0, 4'd0, 0, 0, 0, 0, 0, "sat_hold");

      // Asynchronous reset while Q=7 and Wrap=1, between edges
      rst[2] = 1'b1;
      step(2, 0, 0, 4'd0, 1, 1, 0, 1, 0, "ar_dn0");
      en[2] = 1'b0;
      sb.push_back('{2, 7, 1'b0, 1'b1, "ar_pre"});
      @(negedge clk);
      #2;
      rst[2] = 1'b0;
      #1;
      sb.push_back('{2, 0, 1'b0, 1'b0, "ar_async"});
      ->chk_ev;
      #1;
      en[2] = 1'b1; dnup[2] = 1'b0;
      rst[2] = 1'b1;
      @(posedge clk); #1;
      step(2, 0, 0, 4'd0, 0, 0, 1, 0, 0, "ar_first");

      // Cascade 00..99 then 00, 01; tens stage wraps once
      rst[3] = 1'b1;
      for (int i = 0; i < 102; i++)
         step(3, 0, 0, 4'd0, 1, 0, i % 100, (i % 100) == 99, i == 100, "cascade");

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised synchronous binary up/down counter, the successor to the fixed 4-bit JK-based up/down counter. It adds configurable width and modulus, count enable, synchronous clear and parallel load, and a selectable wrap or saturate mode. It also provides terminal-count and wrap-event outputs so instances can be cascaded or used as timebases in the lab designs.

## Interface
- WIDTH, 4: counter register width in bits; legal range 1..16.
- MODULUS, 2**WIDTH: count range is 0..MODULUS-1; legal range 2..2**WIDTH. Use 10 for a decade counter.
- SATURATE, 0: 0 = wrap at the bounds; 1 = hold at the bounds.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Clr  in  1  synchronous clear to 0; highest synchronous priority.
- Load  in  1  synchronous parallel load of D.
- D  in  WIDTH  load value.
- En  in  1  count enable.
- DNUP  in  1  direction: 0 = count up, 1 = count down.
- Q  out  WIDTH  current count, registered.
- TC  out  1  terminal count, combinational. High when En=1 and (DNUP=0 and Q=MODULUS-1, or DNUP=1 and Q=0).
- Wrap  out  1  registered one-cycle pulse, high in the cycle after the count wrapped.

## Operation
- Reset: ResetN=0 forces Q=0 and Wrap=0 immediately, independent of CLK, and holds them while low.
- Per rising edge, priority Clr > Load > En:
  - Clr=1: Q <= 0.
  - Load=1: Q <= D if D <= MODULUS-1, otherwise Q <= MODULUS-1 (clamp).
  - En=1, DNUP=0: if Q < MODULUS-1, Q <= Q+1; otherwise Q <= 0 (SATURATE=0) or Q holds (SATURATE=1).
  - En=1, DNUP=1: if Q > 0, Q <= Q-1; otherwise Q <= MODULUS-1 (SATURATE=0) or Q holds (SATURATE=1).
  - En=0 and no Clr/Load: Q holds.
- Wrap <= 1 only on an edge where a count step crosses a bound: MODULUS-1 -> 0 going up, or 0 -> MODULUS-1 going down. Otherwise Wrap <= 0.
  - Wrap is never set by Clr, by Load, or in SATURATE=1.
- TC is high in saturate mode while the counter is pinned at a bound with En=1. This is intentional and lets cascade logic detect the limit.
- Cascading: drive the next stage's En from this stage's TC, and share CLK and DNUP.
- Arithmetic: unsigned, modulo MODULUS. Q never takes a value >= MODULUS, even during reset release or a direction change.
- A direction change takes effect on the same edge DNUP is sampled. There is no turnaround cycle.

## Timing
- Q latency: one edge from sampled Clr/Load/En/DNUP to the new Q.
- TC follows Q, En and DNUP combinationally, with no added register delay.
- Wrap is high for exactly one cycle, in the cycle after the wrapping edge.
- Reset release: the first rising edge after ResetN goes high is an ordinary operating edge. Clr/Load/En on that edge take effect normally.
- Reset mid-count: Q and Wrap drop to 0 asynchronously. Any in-progress Wrap pulse is truncated.
- All inputs must be stable around the rising edge of CLK. No internal synchronisation.

## Test plan
- Decade up count (WIDTH=4, MODULUS=10, SATURATE=0): ResetN low then high, En=1, DNUP=0 for 12 edges.
  - Q goes 1..9, 0, 1, 2.
  - TC=1 only while Q=9.
  - Wrap=1 only in the cycle after 9->0.
- Decade down count: same configuration, DNUP=1, starting from Q=0, 3 edges.
  - Q goes 9, 8, 7.
  - TC=1 at Q=0.
  - Wrap pulses after 0->9.
- Saturate (WIDTH=4, MODULUS=16, SATURATE=1): Load D=14, then up for 4 edges.
  - Q goes 14, 15, 15, 15.
  - TC=1 at Q=15.
  - Wrap stays 0.
  - Then DNUP=1 from Load D=1 for 3 edges: Q goes 0, 0, 0.
- Priority and clamp (MODULUS=10): Clr=1, Load=1, D=5, En=1 together -> Q=0.
  - Then Load=1, D=13 -> Q=9, Wrap=0.
  - Then En=0 for 3 edges -> Q holds 9, TC=0.
- Asynchronous reset mid-count: with Q=7 and Wrap=1, pull ResetN low between edges.
  - Q=0 and Wrap=0 before the next edge.
  - After release with En=1 and DNUP=0, the first edge gives Q=1.
- Cascade (two instances, WIDTH=4, MODULUS=10): second stage En = first stage TC, En=1, up for 100 edges.
  - Combined reading goes 00..99 then 00.
  - The second stage's Wrap pulses once, after 99->00.
